// File: rtl/prescale_detector_if.sv
// Bus between the prescale detector and its environment:
// divided-clock tick stream in, recovered one-hot prescale code out.
interface prescale_detector_if;
  logic       en;
  logic       tick;
  logic [5:0] prescale;
  logic       valid;
  logic       err;

  modport master (output en, output tick, input prescale, input valid, input err);
  modport slave  (input en, input tick, output prescale, output valid, output err);
endinterface

// File: rtl/prescale_detector.sv
// Recovers the one-hot prescale code from a divided-clock tick stream by timing
// the interval between ticks and locking after LOCK_CNT equal legal intervals.
module prescale_detector #(
  parameter int CNT_WIDTH = 4,
  parameter int LOCK_CNT  = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  prescale_detector_if.slave bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TMO    = CNT_WIDTH'(TIMEOUT);
  localparam logic [MW-1:0]        MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]        MATCH_LOCK = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [CNT_WIDTH-1:0] cand, cand_d;
  logic [MW-1:0]        match, match_d;
  logic [5:0]           prescale_r, prescale_d;
  logic                 valid_r, valid_d;
  logic                 err_r, err_d;

  function automatic logic is_legal(input logic [CNT_WIDTH-1:0] iv);
    return (iv == CNT_WIDTH'(1)) || (iv == CNT_WIDTH'(2)) ||
           (iv == CNT_WIDTH'(4)) || (iv == CNT_WIDTH'(8));
  endfunction

  function automatic logic [5:0] code_of(input logic [CNT_WIDTH-1:0] iv);
    logic [5:0] c;
    c = 6'b100000;
    if (iv == CNT_WIDTH'(2))      c = 6'b010000;
    else if (iv == CNT_WIDTH'(4)) c = 6'b001000;
    else if (iv == CNT_WIDTH'(8)) c = 6'b000100;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      match      <= '0;
      prescale_r <= 6'b100000;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cand       <= cand_d;
      match      <= match_d;
      prescale_r <= prescale_d;
      valid_r    <= valid_d;
      err_r      <= err_d;
    end
  end

  // cnt holds the cycles since the last tick, so on a tick it is the interval itself.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cand_d     = cand;
    match_d    = match;
    prescale_d = prescale_r;
    valid_d    = valid_r;
    err_d      = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      match_d = '0;
      cnt_d   = '0;
    end else if (state == IDLE) begin
      cnt_d = '0;
      if (bus.tick) begin
        cnt_d   = CNT_ONE;
        match_d = '0;
        state_d = MEASURE;
      end
    end else if (!bus.tick) begin
      if (cnt == CNT_TMO) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
        match_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ONE;
      if (!is_legal(cnt)) begin
        err_d   = 1'b1;
        match_d = '0;
        valid_d = 1'b0;
        state_d = MEASURE;
      end else begin
        if (cnt == cand) begin
          if (match != MATCH_LOCK) match_d = match + MATCH_ONE;
        end else begin
          cand_d  = cnt;
          match_d = MATCH_ONE;
          if (state == LOCKED) begin
            valid_d = 1'b0;
            state_d = MEASURE;
          end
        end
        // Only a measuring detector may lock; a locked one that just lost its ratio must re-measure.
        if (state == MEASURE && match_d == MATCH_LOCK) begin
          prescale_d = code_of(cand_d);
          valid_d    = 1'b1;
          state_d    = LOCKED;
        end
      end
    end
  end

  assign bus.prescale = prescale_r;
  assign bus.valid    = valid_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_prescale_detector.sv
// Self-checking bench for prescale_detector: directed scenarios plus random tick
// streams, all compared against a timestamp-based reference model.
module tb_prescale_detector;
  localparam int LOCK_CNT = 2;
  localparam int TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   passes;

  prescale_detector_if bus();

  prescale_detector #(.CNT_WIDTH(4), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: works from tick timestamps and runs of equal intervals.
  int         m_cyc, m_last, m_run_len, m_run_val;
  bit         m_armed, m_locked, m_err;
  logic [5:0] m_code;

  function automatic void model_step(input bit r, input bit e, input bit t);
    int iv;
    m_cyc++;
    m_err = 1'b0;
    if (r) begin
      m_armed = 0; m_locked = 0; m_run_len = 0; m_code = 6'b100000;
    end else if (!e) begin
      m_armed = 0; m_locked = 0; m_run_len = 0;
    end else if (!m_armed) begin
      if (t) begin m_armed = 1; m_last = m_cyc; m_run_len = 0; end
    end else if (t) begin
      iv = m_cyc - m_last;
      m_last = m_cyc;
      if (iv == 1 || iv == 2 || iv == 4 || iv == 8) begin
        if (m_run_len > 0 && iv == m_run_val) begin
          m_run_len++;
          if (!m_locked && m_run_len >= LOCK_CNT) begin
            m_locked = 1;
            m_code   = 6'b100000 >> $clog2(iv);
          end
        end else begin
          m_run_val = iv; m_run_len = 1; m_locked = 0;
        end
      end else begin
        m_err = 1; m_run_len = 0; m_locked = 0;
      end
    end else if (m_cyc - m_last == TIMEOUT) begin
      m_err = 1; m_locked = 0; m_run_len = 0; m_armed = 0;
    end
  endfunction

  bit qr[$], qe[$], qt[$];

  function automatic void push(input bit r, input bit e, input bit t);
    qr.push_back(r); qe.push_back(e); qt.push_back(t);
  endfunction

  function automatic void start_pattern();
    qr.delete(); qe.delete(); qt.delete();
    push(1, 1, 0);
  endfunction

  function automatic void add_ticks(input int period, input int count);
    for (int c = 0; c < count; c++)
      for (int k = 0; k < period; k++) push(0, 1, k == 0);
  endfunction

  function automatic void add_idle(input int n);
    for (int k = 0; k < n; k++) push(0, 1, 0);
  endfunction

  function automatic void add_en_low(input int n);
    for (int k = 0; k < n; k++) push(0, 0, 1'($urandom_range(0, 1)));
  endfunction

  task automatic run_cycle(input bit r, input bit e, input bit t);
    rst = r; bus.en = e; bus.tick = t;
    @(posedge clk);
    model_step(r, e, t);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {6'b100000, 1'b0, 1'b0})
        $display("[TB] FAIL reset: got %b/%b/%b expected 100000/0/0", bus.prescale, bus.valid, bus.err);
      else passes++;
    end
  endtask

  task automatic test_div4();
    int base;
    start_pattern(); base = qt.size(); add_ticks(4, 5);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL div4 @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i == base + 8) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.prescale !== 6'b001000 || bus.err !== 1'b0)
          $display("[TB] FAIL div4_lock: got %b/%b/%b expected 001000/1/0", bus.prescale, bus.valid, bus.err);
        else passes++;
      end
    end
  endtask

  task automatic test_div1();
    int base;
    start_pattern(); base = qt.size(); add_ticks(1, 6);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL div1 @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i == base + 1 || i == base + 2) begin
        checks++;
        if (bus.valid !== (i == base + 2) || bus.prescale !== 6'b100000)
          $display("[TB] FAIL div1_lock @%0d: got %b/%b expected 100000/%0d", i, bus.prescale, bus.valid, i == base + 2);
        else passes++;
      end
    end
  endtask

  task automatic test_ratio_change();
    int b8;
    start_pattern(); add_ticks(2, 4); b8 = qt.size(); add_ticks(8, 3);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL ratio_change @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i == b8 + 8 || i == b8 + 12) begin
        checks++;
        if (bus.valid !== 1'b0 || bus.prescale !== 6'b010000)
          $display("[TB] FAIL ratio_change_drop @%0d: got %b/%b expected 010000/0", i, bus.prescale, bus.valid);
        else passes++;
      end
      if (i == b8 + 16) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.prescale !== 6'b000100)
          $display("[TB] FAIL ratio_change_relock: got %b/%b expected 000100/1", bus.prescale, bus.valid);
        else passes++;
      end
    end
  endtask

  task automatic test_illegal();
    int e;
    start_pattern(); add_ticks(4, 4); push(0, 1, 0); e = qt.size(); add_ticks(4, 3);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL illegal @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i == e || i == e + 1 || i == e + 4) begin
        checks++;
        if (bus.err !== (i == e) || bus.valid !== 1'b0)
          $display("[TB] FAIL illegal_err @%0d: got err=%b valid=%b expected err=%0d valid=0", i, bus.err, bus.valid, i == e);
        else passes++;
      end
      if (i == e + 8) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.prescale !== 6'b001000)
          $display("[TB] FAIL illegal_relock: got %b/%b expected 001000/1", bus.prescale, bus.valid);
        else passes++;
      end
    end
  endtask

  task automatic test_timeout();
    int tmo;
    start_pattern(); tmo = qt.size() + 24 + TIMEOUT; add_ticks(8, 4); add_idle(20);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL timeout @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i >= tmo - 1 && i <= tmo + 1) begin
        checks++;
        if (bus.err !== (i == tmo) || bus.valid !== (i < tmo) || bus.prescale !== 6'b000100)
          $display("[TB] FAIL timeout_edge @%0d: got %b/%b/%b expected 000100/%0d/%0d", i, bus.prescale, bus.valid, bus.err, i < tmo, i == tmo);
        else passes++;
      end
    end
  endtask

  task automatic test_enable();
    int m;
    start_pattern(); add_ticks(4, 5); m = qt.size(); add_en_low(3); add_ticks(2, 4);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL enable @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i >= m && i < m + 3) begin
        checks++;
        if ({bus.prescale, bus.valid, bus.err} !== {6'b001000, 1'b0, 1'b0})
          $display("[TB] FAIL enable_low @%0d: got %b/%b/%b expected 001000/0/0", i, bus.prescale, bus.valid, bus.err);
        else passes++;
      end
      if (i == m + 7) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.prescale !== 6'b010000)
          $display("[TB] FAIL enable_relock: got %b/%b expected 010000/1", bus.prescale, bus.valid);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_locked();
    int r;
    start_pattern(); add_ticks(4, 4); r = qt.size(); push(1, 1, 1); add_idle(2);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL reset_locked @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i == r - 1 || i == r) begin
        checks++;
        if (bus.valid !== (i == r - 1) || bus.prescale !== ((i == r) ? 6'b100000 : 6'b001000))
          $display("[TB] FAIL reset_locked_edge @%0d: got %b/%b", i, bus.prescale, bus.valid);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    start_pattern(); base = qt.size(); add_ticks(3, 5);
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL back_to_back @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
      if (i > base) begin
        checks++;
        if (bus.err !== ((i - base) % 3 == 0))
          $display("[TB] FAIL back_to_back_err @%0d: got %b expected %0d", i, bus.err, (i - base) % 3 == 0);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    int per[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 12};
    int kind;
    start_pattern();
    for (int s = 0; s < 150; s++) begin
      kind = $urandom_range(0, 11);
      if (kind == 0) add_en_low($urandom_range(1, 3));
      else if (kind == 1) add_idle($urandom_range(14, 20));
      else if (kind == 2) push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else add_ticks(per[$urandom_range(0, 9)], $urandom_range(1, 5));
    end
    foreach (qt[i]) begin
      run_cycle(qr[i], qe[i], qt[i]);
      checks++;
      if ({bus.prescale, bus.valid, bus.err} !== {m_code, m_locked, m_err})
        $display("[TB] FAIL random @%0d: got %b/%b/%b expected %b/%b/%b", i, bus.prescale, bus.valid, bus.err, m_code, m_locked, m_err);
      else passes++;
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    rst = 1'b1; bus.en = 1'b0; bus.tick = 1'b0;
    m_cyc = 0; m_last = 0; m_run_len = 0; m_run_val = 0;
    m_armed = 0; m_locked = 0; m_err = 0; m_code = 6'b100000;
    test_reset();
    test_div4();
    test_div1();
    test_ratio_change();
    test_illegal();
    test_timeout();
    test_enable();
    test_reset_locked();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/prescale_detector.md
# prescale_detector

Measurement block that recovers the one-hot prescale code from an observed divided-clock tick stream: the inverse of the prescale-to-divide-ratio mapping used by the clock divider path. It counts reference-clock cycles between consecutive TICK pulses. It classifies each interval as a legal ratio (1, 2, 4 or 8) and, after a programmable number of consecutive matching intervals, publishes the matching 6-bit one-hot prescale code with a valid flag. It sits beside the clock divider in the multi-clock system and is used to self-check and report the active divide ratio back to the register file.

## Interface
- CNT_WIDTH, 4: interval counter width; must satisfy 2^CNT_WIDTH > TIMEOUT.
- LOCK_CNT, 2: number of consecutive equal legal intervals required to lock (≥1).
- TIMEOUT, 15: cycles without TICK before lock is dropped; must be > 8.
- CLK  in  1  single clock.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  detector enable; low = synchronous return to IDLE.
- TICK  in  1  one-cycle pulse per divided-clock period, synchronous to CLK; held high continuously means ratio 1.
- PRESCALE  out  6  one-hot code: 6'b100000 = /1, 6'b010000 = /2, 6'b001000 = /4, 6'b000100 = /8.
- VALID  out  1  high while locked; PRESCALE is trustworthy.
- ERR  out  1  one-cycle pulse on an illegal interval or timeout.

## Operation
- States: IDLE, MEASURE, LOCKED.
- Internal registers: cnt (CNT_WIDTH), cand (last legal interval), match (count of consecutive equal intervals).
- IDLE: cnt held at 0. TICK → cnt=1, match=0, go to MEASURE.
- MEASURE/LOCKED, no TICK: cnt=cnt+1, saturating at TIMEOUT.
- MEASURE/LOCKED, TICK: interval = cnt, then cnt=1.
  - Interval in {1,2,4,8} and equal to cand: match=match+1, saturating at LOCK_CNT.
  - Interval legal and not equal to cand: cand=interval, match=1. In LOCKED, VALID drops and the state goes to MEASURE.
  - Interval illegal (3,5,6,7, or >8): ERR pulse, match=0, VALID=0, state goes to MEASURE.
- When match reaches LOCK_CNT in MEASURE: PRESCALE=code(cand), VALID=1, state goes to LOCKED.
- LOCKED, matching interval: no output change.
- Timeout: no TICK and cnt==TIMEOUT in MEASURE/LOCKED → ERR pulse, VALID=0, match=0, state goes to IDLE.
- PRESCALE holds its last locked code when VALID drops. It changes only on lock.
- EN low: state=IDLE, VALID=0, match=0, cnt=0, ERR=0. PRESCALE is retained. EN low overrides TICK in the same cycle.
- Arithmetic: interval compare uses the full CNT_WIDTH value. No wrap is possible because cnt saturates.

## Timing
- Reset values: PRESCALE=6'b100000, VALID=0, ERR=0, state=IDLE, cnt=0, cand=0, match=0.
- RST dominates EN and TICK. Assertion mid-measurement clears everything on the next edge.
- All outputs are registered and update on the edge that samples the qualifying TICK.
- Lock latency from the first TICK: LOCK_CNT × ratio cycles (LOCK_CNT+1 ticks).
- ERR is high for exactly one cycle per event and is never high for two consecutive cycles from one event.
- Timeout fires on the edge where cnt would exceed TIMEOUT with no TICK present.
- A TICK arriving on that same edge is treated as a normal interval; timeout does not fire.

## Test plan
- Reset then TICK every 4 cycles, LOCK_CNT=2 → VALID=1 and PRESCALE=6'b001000 on the edge sampling the 3rd tick; ERR stays 0.
- TICK held high continuously → PRESCALE=6'b100000 and VALID=1 on the 3rd sampled tick.
- Locked at /2, then switch to TICK every 8 cycles → VALID drops on the first 8-interval, relocks PRESCALE=6'b000100 two intervals later; PRESCALE reads 6'b010000 in between.
- Locked at /4, then one interval of 5 → ERR one-cycle pulse, VALID=0, state MEASURE; relock after two further 4-intervals.
- Locked at /8, then TICK stops → ERR pulse and VALID=0 when cnt reaches 15; state IDLE; PRESCALE still 6'b000100.
- EN low for 3 cycles mid-measurement, and separately RST asserted while locked → VALID=0 next edge. The EN case retains PRESCALE; the RST case shows PRESCALE=6'b100000.
